// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction encoder/loader and opcode decoder.
// Field positions are the LSB of each field within the 32-bit instruction word.
package isa_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_BAD} fmt_e;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} load_state_e;

  function automatic fmt_e op_format(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_RTYPE:              f = FMT_R;
      OP_ADDI, OP_SW, OP_LW: f = FMT_I;
      default:               f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO holding encoded words plus their last flag.
// A push while full is taken when a pop happens in the same cycle; flush empties it.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (count == (PW+1)'(DEPTH));
  assign rdata   = mem_q[rd_q[PW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q[PW-1:0]] = wdata;
        wr_d = wr_q + (PW+1)'(1);
      end
      if (do_pop) rd_d = rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Packs instruction field bundles into R/I words and streams them into imem, holding the CPU in reset meanwhile.
//   state   | meaning
//   LD_IDLE | after reset, waiting for start; cpu held
//   LD_LOAD | accepting bundles and draining encoded words to imem
//   LD_DONE | program loaded (or imem full); cpu released
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int FIFO_D = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_opcode,
  output logic              full
);

  localparam int CW = $clog2(FIFO_D) + 1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_acc_q, last_acc_d;
  logic              last_bad_q, last_bad_d;
  logic              err_q, err_d;
  logic              full_q, full_d;

  fmt_e              fmt;
  logic              accept, push, pop, flush, bad_last, final_wr, at_top;
  logic [31:0]       enc_word;
  logic [32:0]       head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign fmt      = op_format(in_opcode);
  assign accept   = in_valid & in_ready;
  assign push     = accept & (fmt != FMT_BAD);
  assign pop      = imem_we & imem_ready;
  assign bad_last = accept & in_last & (fmt == FMT_BAD);
  assign at_top   = (addr_q == {ADDR_W{1'b1}});
  // A last carried by a dropped bundle makes the final buffered word the last write.
  assign final_wr = pop & (head[32] | ((last_bad_q | bad_last) & (fifo_count == CW'(1))));

  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_R: enc_word = (32'(in_opcode) << OP_LSB) | (32'(in_rd) << RD_LSB) |
                        (32'(in_rs) << RS_LSB) | (32'(in_rt) << RT_LSB) |
                        (32'(in_shamt) << SHAMT_LSB) | (32'(in_aluop) << ALUOP_LSB);
      FMT_I: enc_word = (32'(in_opcode) << OP_LSB) | (32'(in_rd) << RD_LSB) |
                        (32'(in_rs) << RS_LSB) | 32'(in_imm);
      default: enc_word = '0;
    endcase
  end

  enc_fifo #(.DEPTH(FIFO_D), .W(33)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ({in_last, enc_word}),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_acc_d = last_acc_q;
    last_bad_d = last_bad_q;
    err_d      = err_q;
    full_d     = full_q;
    flush      = 1'b0;
    case (state_q)
      LD_LOAD: begin
        if (accept & in_last) last_acc_d = 1'b1;
        if (bad_last) last_bad_d = 1'b1;
        if (accept & (fmt == FMT_BAD)) err_d = 1'b1;
        if (pop & ~at_top) addr_d = addr_q + ADDR_W'(1);
        if (final_wr | (pop & at_top) | (bad_last & fifo_empty)) begin
          state_d = LD_DONE;
          flush   = 1'b1;
          full_d  = pop & at_top & ~final_wr;
        end
      end
      default: begin
        if (start) begin
          state_d    = LD_LOAD;
          addr_d     = '0;
          last_acc_d = 1'b0;
          last_bad_d = 1'b0;
          err_d      = 1'b0;
          full_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LD_IDLE;
      addr_q     <= '0;
      last_acc_q <= 1'b0;
      last_bad_q <= 1'b0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_acc_q <= last_acc_d;
      last_bad_q <= last_bad_d;
      err_q      <= err_d;
      full_q     <= full_d;
    end
  end

  assign in_ready   = (state_q == LD_LOAD) & ~fifo_full & ~last_acc_q;
  assign imem_we    = (state_q == LD_LOAD) & ~fifo_empty;
  assign imem_addr  = addr_q;
  assign imem_data  = fifo_empty ? 32'd0 : head[31:0];
  assign cpu_hold   = (state_q != LD_DONE);
  assign done       = (state_q == LD_DONE);
  assign err_opcode = err_q;
  assign full       = full_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected imem writes are queued from a program-level model
// and popped by an independent monitor whenever the DUT performs a write.
module tb_instr_encode_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int FD    = 2;

  typedef struct {
    logic [4:0]  op, rd, rs, rt, shamt, aluop;
    logic [16:0] imm;
    bit          last;
  } bundle_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
  logic [16:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic          imem_ready = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          cpu_hold, done, err_opcode, full;

  wr_t     exp_q[$];
  bundle_t prog[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      rdy_mode = 0;

  instr_encode_loader #(.ADDR_W(AW), .FIFO_D(FD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_shamt   (in_shamt),
    .in_aluop   (in_aluop),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err_opcode (err_opcode),
    .full       (full)
  );

  initial forever #5 clock = ~clock;

  // imem backpressure: 0 = always ready, 1 = random, 2 = stalled
  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       imem_ready = 1'b1;
      1:       imem_ready = ($urandom_range(0, 2) != 0);
      default: imem_ready = 1'b0;
    endcase
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (imem_we === 1'b1 && imem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_unexpected addr=%0d data=%h @%0t", imem_addr, imem_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk32("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk32("wr_data", imem_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout @%0t", $time);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic bit is_bad(input logic [4:0] op);
    return !(op == 5'd0 || op == 5'd5 || op == 5'd7 || op == 5'd8);
  endfunction

  function automatic logic [31:0] ref_encode(input bundle_t b);
    if (b.op == 5'd0) return {b.op, b.rd, b.rs, b.rt, b.shamt, b.aluop, 2'b00};
    return {b.op, b.rd, b.rs, b.imm};
  endfunction

  function automatic bundle_t mk(input logic [4:0] op, rd, rs, rt, sh, al,
                                 input logic [16:0] imm, input bit last);
    bundle_t b;
    b.op = op; b.rd = rd; b.rs = rs; b.rt = rt; b.shamt = sh; b.aluop = al;
    b.imm = imm; b.last = last;
    return b;
  endfunction

  task automatic push_exp(input int addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Program-level model: valid words land at consecutive addresses until imem is full;
  // full is flagged when the word filling the last address is not the program's last.
  task automatic model_program(output bit e_err, output bit e_full);
    int nv = 0;
    e_err  = 0;
    e_full = 0;
    foreach (prog[i]) begin
      if (is_bad(prog[i].op)) begin
        if (nv < DEPTH) e_err = 1;
      end else begin
        if (nv < DEPTH) push_exp(nv, ref_encode(prog[i]));
        nv++;
        if (nv == DEPTH) e_full = !prog[i].last;
      end
    end
  endtask

  function automatic logic [4:0] pick_good();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd7;
      default: return 5'd8;
    endcase
  endfunction

  function automatic logic [4:0] pick_bad();
    logic [4:0] op;
    do op = 5'($urandom); while (!is_bad(op));
    return op;
  endfunction

  // Bad opcodes only before imem capacity is reached, so every one is certain to be accepted.
  task automatic gen_random(input bit force_nolast, input bit allow_bad);
    bit has_last;
    int n, nv;
    prog.delete();
    nv = 0;
    has_last = force_nolast ? 1'b0 : ($urandom_range(0, 3) != 0);
    n = has_last ? int'($urandom_range(1, DEPTH + 2)) : 0;
    for (int i = 0; i < 40; i++) begin
      bundle_t b;
      if (has_last ? (i >= n) : (nv >= DEPTH + 1)) break;
      b = mk(5'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             17'($urandom), has_last && (i == n - 1));
      b.op = (allow_bad && nv < DEPTH && $urandom_range(0, 4) == 0) ? pick_bad() : pick_good();
      if (!is_bad(b.op)) nv++;
      prog.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic send(input bundle_t b, output bit acc);
    acc = 0;
    in_valid = 1'b1;
    in_opcode = b.op; in_rd = b.rd; in_rs = b.rs; in_rt = b.rt;
    in_shamt = b.shamt; in_aluop = b.aluop; in_imm = b.imm; in_last = b.last;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        acc = 1;
        break;
      end
      if (done) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_program(input bit e_err, input bit e_full, input bit chk_lat);
    pulse_start();
    foreach (prog[i]) begin
      bit acc;
      if (done) break;
      if (chk_lat && i == 0) chk1("we_before_accept", imem_we, 1'b0);
      send(prog[i], acc);
      if (chk_lat && i == 0 && acc) chk1("we_latency", imem_we, 1'b1);
    end
    for (int k = 0; k < 400; k++) begin
      if (done) break;
      @(negedge clock);
    end
    chk1("done", done, 1'b1);
    chk1("cpu_hold_released", cpu_hold, 1'b0);
    chk1("we_in_done", imem_we, 1'b0);
    chk1("in_ready_in_done", in_ready, 1'b0);
    chk1("err_opcode", err_opcode, e_err);
    chk1("full", full, e_full);
    chk32("writes_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_imem_we"}, imem_we, 1'b0);
    chk32({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk32({tag, "_imem_data"}, imem_data, 32'd0);
    chk1({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err_opcode, 1'b0);
    chk1({tag, "_full"}, full, 1'b0);
  endtask

  initial begin
    bit e_err, e_full, acc;

    repeat (3) @(posedge clock);
    #1;
    check_reset("rst");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk1("idle_in_ready", in_ready, 1'b0);

    // add r1,r2,r3 with last
    prog.delete();
    prog.push_back(mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 1));
    push_exp(0, 32'h0044_3000);
    drive_program(0, 0, 1);

    // addi / lw / sw
    prog.delete();
    prog.push_back(mk(5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 0));
    prog.push_back(mk(5'd8, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'd8, 0));
    prog.push_back(mk(5'd7, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'd8, 1));
    push_exp(0, 32'h2941_FFFF);
    push_exp(1, 32'h4104_0008);
    push_exp(2, 32'h3904_0008);
    drive_program(0, 0, 0);

    // imem stalled while a 4-word stream arrives
    rdy_mode = 2;
    gen_random(0, 0);
    prog.delete();
    for (int i = 0; i < 4; i++)
      prog.push_back(mk(pick_good(), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        5'($urandom), 17'($urandom), i == 3));
    model_program(e_err, e_full);
    fork
      drive_program(e_err, e_full, 0);
      begin
        repeat (8) @(negedge clock);
        chk1("stall_in_ready", in_ready, 1'b0);
        chk1("stall_we", imem_we, 1'b1);
        rdy_mode = 0;
      end
    join

    // unsupported opcode between two valid words
    prog.delete();
    prog.push_back(mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 17'd0, 0));
    prog.push_back(mk(5'd3, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'h0AAAA, 0));
    prog.push_back(mk(5'd5, 5'd6, 5'd7, 5'd0, 5'd0, 5'd0, 17'h00123, 1));
    model_program(e_err, e_full);
    drive_program(e_err, e_full, 0);

    // DEPTH+1 words without last: imem fills up
    rdy_mode = 1;
    prog.delete();
    for (int i = 0; i <= DEPTH; i++)
      prog.push_back(mk(pick_good(), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        5'($urandom), 17'($urandom), 0));
    model_program(e_err, e_full);
    drive_program(e_err, e_full, 0);

    // reset asserted while the second word is being offered
    rdy_mode = 2;
    repeat (2) @(posedge clock);
    pulse_start();
    send(mk(5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd0, 0), acc);
    chk1("rstmid_first_accepted", acc, 1'b1);
    in_valid = 1'b1; in_opcode = 5'd5; in_rd = 5'd2; in_imm = 17'd7;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("rstmid");
    in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    gen_random(0, 1);
    model_program(e_err, e_full);
    drive_program(e_err, e_full, 0);

    for (int r = 0; r < 14; r++) begin
      rdy_mode = (r % 3 == 0) ? 0 : 1;
      gen_random(r == 5, 1);
      model_program(e_err, e_full);
      drive_program(e_err, e_full, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
